// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter that owns the shared bridge command port.
// The arbiter grants the port to one master per transaction. It latches the
// winner's command at grant time and holds it on the bridge for ISSUE_CYCLES
// cycles. It then returns the captured read data with a one-cycle ack and
// re-arbitrates.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate priority between the
// masters. Without it, m0 always wins simultaneous requests.
//
// Parameters: ISSUE_CYCLES (1..15) command hold time, ADDR_W address width.
// Ports:
//   clk_from_cpu / rst_from_cpu   clock, async active-low reset
//   mX_req/we/addr/wdata          master X command (held until mX_ack)
//   mX_rdata / mX_ack             registered read data, completion pulse
//   we/addr/wdata_to_bridge       bridge command (zero when not issuing)
//   rdata_from_bridge             bridge read data
//   grant                         one-hot owner {m1,m0}; busy = ISSUE|DONE
module bus_arbiter #(
  parameter int unsigned ISSUE_CYCLES = 2,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk_from_cpu,
  input  logic              rst_from_cpu,
  input  logic              m0_req,
  input  logic [1:0]        m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic [31:0]       m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [1:0]        m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic [31:0]       m1_rdata,
  output logic              m1_ack,
  output logic [1:0]        we_to_bridge,
  output logic [ADDR_W-1:0] addr_to_bridge,
  output logic [31:0]       wdata_to_bridge,
  input  logic [31:0]       rdata_from_bridge,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(ISSUE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          grant_q, grant_d;
  logic [31:0]         rdata0_q, rdata0_d;
  logic [31:0]         rdata1_q, rdata1_d;
  logic                win1;
`ifdef ARB_ROUND_ROBIN_EN
  logic                ptr_q, ptr_d;   // 1: m1 has priority
`endif

  always_ff @(posedge clk_from_cpu or negedge rst_from_cpu) begin
    if (!rst_from_cpu) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      grant_q  <= grant_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // m1 wins when it is the only requester, or both request and it holds priority
`ifdef ARB_ROUND_ROBIN_EN
  assign win1 = m1_req & (~m0_req | ptr_q);
`else
  assign win1 = m1_req & ~m0_req;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_d  = grant_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ISSUE;
          cnt_d   = CNT_LOAD;
          grant_d = win1 ? 2'b10 : 2'b01;
          we_d    = win1 ? m1_we    : m0_we;
          addr_d  = win1 ? m1_addr  : m0_addr;
          wdata_d = win1 ? m1_wdata : m0_wdata;
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (grant_q[1]) rdata1_d = rdata_from_bridge;
          else            rdata0_d = rdata_from_bridge;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
        // hand priority to the master that did not just win
        ptr_d   = grant_q[0];
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Bridge outputs decode straight from state so a reset mid-ISSUE idles the port at once
  assign we_to_bridge    = (state_q == ISSUE) ? we_q    : '0;
  assign addr_to_bridge  = (state_q == ISSUE) ? addr_q  : '0;
  assign wdata_to_bridge = (state_q == ISSUE) ? wdata_q : '0;

  assign m0_ack   = (state_q == DONE) & grant_q[0];
  assign m1_ack   = (state_q == DONE) & grant_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter placed between the CPU data port and a second bus master (program loader / DMA) in front of the peripheral bridge. Owns the single shared bridge command port (we/addr/wdata/rdata), grants it to one master per transaction, holds the command for a fixed number of cycles, returns read data and a one-cycle acknowledge, then re-arbitrates.

## Interface
Parameters:
- `ISSUE_CYCLES`, 2: cycles a command is held on the bridge port; legal 1..15.
- `ADDR_W`, 32: address width.

Ports:
- `clk_from_cpu` in 1: the single clock; all state updates on its rising edge.
- `rst_from_cpu` in 1: asynchronous, active-low reset.
- `m0_req` in 1: master 0 (CPU) request; held with its command until `m0_ack`.
- `m0_we` in 2: bit1 = write, bit0 = memory/bus access.
- `m0_addr` in ADDR_W: address.
- `m0_wdata` in 32: write data.
- `m0_rdata` out 32: registered read data, valid while `m0_ack`=1.
- `m0_ack` out 1: one-cycle completion pulse.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_rdata`, `m1_ack`: master 1, identical semantics.
- `we_to_bridge` out 2: command to bridge.
- `addr_to_bridge` out ADDR_W: address to bridge.
- `wdata_to_bridge` out 32: write data to bridge.
- `rdata_from_bridge` in 32: bridge read data (combinational w.r.t. command).
- `grant` out 2: one-hot owner {m1,m0}; 2'b00 when idle.
- `busy` out 1: high in ISSUE or DONE.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: if any `mX_req`, select winner, latch its we/addr/wdata into command registers, set `grant`, load issue counter with ISSUE_CYCLES-1, go ISSUE. No request: stay IDLE.
- ISSUE: drive latched command on bridge port. Counter decrements each cycle; at 0 capture `rdata_from_bridge` into winner's `mX_rdata`, go DONE.
- DONE: bridge port idle; pulse winner's `mX_ack`; update priority; clear `grant`; go IDLE.
- Commands latched at grant; master changes after grant are ignored until ack.
- Idle bridge values: `we_to_bridge`=2'b00, `addr_to_bridge`=0, `wdata_to_bridge`=0.
- Loser's `mX_rdata` keeps its previous value.
- `mX_we`=2'b00 with `mX_req`=1 is still a transaction; bridge sees we=00, rdata captured as-is.
- Priority pointer after ack: points to the master that did not just win.

## Timing
- Reset (async assert, sync-safe release): state IDLE, `grant`=0, `busy`=0, both acks 0, both rdata 0, bridge outputs at idle values, priority pointer = m0.
- Latency: req seen in IDLE at cycle 0 -> command on bridge cycles 1..ISSUE_CYCLES -> ack at cycle ISSUE_CYCLES+1.
- Back-to-back: earliest next grant in the cycle after DONE; throughput one transaction per ISSUE_CYCLES+2 cycles.
- Writes: bridge sees write strobe for all ISSUE_CYCLES cycles; downstream must tolerate repeated write of the same data.
- Simultaneous requests: winner per priority rule; loser waits, served next.
- Request dropped before ack: protocol violation; arbiter still completes and acks.
- Reset mid-ISSUE: transaction abandoned, no ack, bridge port idle immediately.
- Counter width 4 bits; ISSUE_CYCLES=1 means single ISSUE cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: alternating priority via pointer as above.
- Not defined: fixed priority, m0 always wins simultaneous requests; pointer logic removed; m1 can starve.

## Test plan
- Reset: hold `rst_from_cpu`=0 with both reqs high -> grant=00, busy=0, acks 0, we_to_bridge=00.
- Single read: m0 req, we=01, addr=0x100, bridge returns 0x12345678, ISSUE_CYCLES=2 -> bridge addr 0x100 cycles 1-2, m0_ack at cycle 3 with m0_rdata=0x12345678.
- Single write: m1 req, we=11, addr=0x200, wdata=0xCAFEF00D -> bridge we=11 for 2 cycles, m1_ack at cycle 3, m0_ack never.
- Contention: both req continuously -> with macro grants alternate m0,m1,m0,m1; without macro only m0 acked.
- Reset mid-ISSUE: assert reset during cycle 1 of m1 write -> outputs idle same cycle, no m1_ack after release until new req.
- Command change after grant: m0 changes addr 0x100->0x300 in cycle 2 -> bridge keeps 0x100 throughout.
